rrf_tag_allocator: RTL and testbench

Free-list manager for the renaming register file (RRF) in the superscalar core. At dispatch it hands out free RRF entry tags for destination renaming. At commit it takes released tags back. It is the allocation/release end of the RRF write-side interface. The decode/dispatch stage consumes the tags, and the ROB/commit stage returns them.

---
 rtl/rrf_tag_allocator.sv | 96 +++++++++
 tb/tb_rrf_tag_allocator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_tag_allocator.sv
// ============================================================================
//  Module   : rrf_tag_allocator
//  Purpose  : Free-list manager for RRF destination tags (dispatch alloc,
//             commit release) built on a circular FIFO plus a busy bitmap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rrf_tag_allocator #(
  parameter int NUM_TAGS = 16,
  parameter int TAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 alloc_req,
  output logic                 alloc_valid,
  output logic [TAG_W-1:0]     alloc_tag,
  output logic                 alloc_fire,
  input  logic                 free_en,
  input  logic [TAG_W-1:0]     free_tag,
  output logic                 free_err,
  output logic [TAG_W:0]       free_count,
  output logic [NUM_TAGS-1:0]  busy_vec
);

  localparam logic [TAG_W:0] c_full_count = (TAG_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0]    r_fifo [NUM_TAGS];
  logic [TAG_W-1:0]    r_head;
  logic [TAG_W-1:0]    r_tail;
  logic [TAG_W:0]      r_count;
  logic [NUM_TAGS-1:0] r_busy;
  logic                r_free_err;

  logic                w_alloc_valid;
  logic [TAG_W-1:0]    w_alloc_tag;
  logic                w_alloc_fire;
  logic                w_free_legal;
  logic [NUM_TAGS-1:0] w_busy_nxt;
  logic [TAG_W:0]      w_count_nxt;

  assign w_alloc_valid = (r_count != '0);
  assign w_alloc_tag   = r_fifo[r_head];
  assign w_alloc_fire  = alloc_req & w_alloc_valid;

  // Freeing the tag that is being handed out this very cycle is rejected.
  assign w_free_legal = free_en & r_busy[free_tag] &
                        ~(w_alloc_fire && (free_tag == w_alloc_tag));

  always_comb begin
    w_busy_nxt  = r_busy;
    w_count_nxt = r_count;
    if (w_alloc_fire) w_busy_nxt[w_alloc_tag] = 1'b1;
    if (w_free_legal) w_busy_nxt[free_tag]    = 1'b0;
    case ({w_alloc_fire, w_free_legal})
      2'b10:   w_count_nxt = r_count - 1'b1;
      2'b01:   w_count_nxt = r_count + 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= c_full_count;
      r_busy     <= '0;
      r_free_err <= 1'b0;
    end else begin
      if (w_alloc_fire) r_head <= r_head + 1'b1;
      if (w_free_legal) r_tail <= r_tail + 1'b1;
      r_count    <= w_count_nxt;
      r_busy     <= w_busy_nxt;
      r_free_err <= free_en & ~w_free_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_TAGS; i++) r_fifo[i] <= TAG_W'(i);
    end else if (w_free_legal) begin
      r_fifo[r_tail] <= free_tag;
    end
  end

  assign alloc_valid = w_alloc_valid;
  assign alloc_tag   = w_alloc_tag;
  assign alloc_fire  = w_alloc_fire;
  assign free_err    = r_free_err;
  assign free_count  = r_count;
  assign busy_vec    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rrf_tag_allocator.sv
// ============================================================================
//  Module   : tb_rrf_tag_allocator
//  Purpose  : Directed self-checking bench for rrf_tag_allocator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rrf_tag_allocator;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        alloc_req;
  logic        alloc_valid;
  logic [3:0]  alloc_tag;
  logic        alloc_fire;
  logic        free_en;
  logic [3:0]  free_tag;
  logic        free_err;
  logic [4:0]  free_count;
  logic [15:0] busy_vec;

  int total;
  int bad;

  rrf_tag_allocator #(.NUM_TAGS(16), .TAG_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_req   (alloc_req),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .alloc_fire  (alloc_fire),
    .free_en     (free_en),
    .free_tag    (free_tag),
    .free_err    (free_err),
    .free_count  (free_count),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive-only helpers (no checking): inputs change on the falling edge.
  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; alloc_req = 1'b0; free_en = 1'b0; free_tag = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
      alloc_req = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (free_count !== 5'd16) begin bad++; $display("FAIL reset_count got=%0d exp=16", free_count); end
    total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL reset_valid got=%b exp=1", alloc_valid); end
    total++; if (alloc_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", alloc_tag); end
    total++; if (busy_vec !== 16'h0000) begin bad++; $display("FAIL reset_busy got=%h exp=0000", busy_vec); end
    total++; if (free_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", free_err); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
      alloc_req = 1'b1;
      #1;
      total++; if (alloc_tag !== 4'(i) || alloc_valid !== 1'b1 || alloc_fire !== 1'b1) begin
        bad++; $display("FAIL fill_tag[%0d] got tag=%0d valid=%b fire=%b exp tag=%0d valid=1 fire=1",
                        i, alloc_tag, alloc_valid, alloc_fire, i);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (free_count !== 5'd0) begin bad++; $display("FAIL fill_count got=%0d exp=0", free_count); end
    total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL fill_valid got=%b exp=0", alloc_valid); end
    total++; if (busy_vec !== 16'hFFFF) begin bad++; $display("FAIL fill_busy got=%h exp=ffff", busy_vec); end
    alloc_req = 1'b1;
    #1;
    total++; if (alloc_fire !== 1'b0) begin bad++; $display("FAIL fill_17th_fire got=%b exp=0", alloc_fire); end
    @(posedge clk); #1;
    total++; if (free_count !== 5'd0) begin bad++; $display("FAIL fill_17th_count got=%0d exp=0", free_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_free_order();
    logic [3:0] order [3];
    order[0] = 4'd5; order[1] = 4'd2; order[2] = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      free_en = 1'b1; free_tag = order[i];
      if (i == 0) begin
        #1;
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL free_no_bypass got valid=%b exp=0", alloc_valid); end
      end
      @(posedge clk); #1;
      if (i == 0) begin
        total++; if (alloc_valid !== 1'b1 || alloc_tag !== 4'd5) begin
          bad++; $display("FAIL free_next_cycle got valid=%b tag=%0d exp valid=1 tag=5", alloc_valid, alloc_tag);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (free_count !== 5'd3) begin bad++; $display("FAIL free_count got=%0d exp=3", free_count); end
    total++; if (busy_vec !== 16'hFDDB) begin bad++; $display("FAIL free_busy got=%h exp=fddb", busy_vec); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      alloc_req = 1'b1;
      #1;
      total++; if (alloc_tag !== order[i] || alloc_fire !== 1'b1) begin
        bad++; $display("FAIL free_order[%0d] got tag=%0d fire=%b exp tag=%0d fire=1", i, alloc_tag, alloc_fire, order[i]);
      end
      @(posedge clk); #1;
    end
    total++; if (free_count !== 5'd0 || busy_vec !== 16'hFFFF) begin
      bad++; $display("FAIL free_realloc got count=%0d busy=%h exp count=0 busy=ffff", free_count, busy_vec);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_free_err();
    do_reset();
    free_en = 1'b1; free_tag = 4'd7;
    @(posedge clk); #1;
    @(negedge clk);
    idle_inputs();
    total++; if (free_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", free_err); end
    total++; if (free_count !== 5'd16 || alloc_tag !== 4'd0) begin
      bad++; $display("FAIL err_nochange got count=%0d tag=%0d exp count=16 tag=0", free_count, alloc_tag);
    end
    @(posedge clk); #1;
    total++; if (free_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b exp=0", free_err); end
    alloc_n(1);
    free_en = 1'b1; free_tag = 4'd0;
    @(posedge clk); #1;
    total++; if (free_err !== 1'b0 || free_count !== 5'd16) begin
      bad++; $display("FAIL err_first_free got err=%b count=%0d exp err=0 count=16", free_err, free_count);
    end
    @(posedge clk); #1;
    total++; if (free_err !== 1'b1 || free_count !== 5'd16) begin
      bad++; $display("FAIL err_double_free got err=%b count=%0d exp err=1 count=16", free_err, free_count);
    end
    @(negedge clk);
    idle_inputs();
    total++; if (alloc_tag !== 4'd1 || busy_vec !== 16'h0000) begin
      bad++; $display("FAIL err_state got tag=%0d busy=%h exp tag=1 busy=0000", alloc_tag, busy_vec);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_n(8);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        idle_inputs();
        alloc_req = 1'b1; free_en = 1'b1;
        free_tag  = (r == 0) ? 4'(k) : 4'(k + 8);
        #1;
        total++; if (alloc_tag !== ((r == 0) ? 4'(k + 8) : 4'(k))) begin
          bad++; $display("FAIL b2b_tag[%0d][%0d] got=%0d exp=%0d", r, k, alloc_tag, (r == 0) ? k + 8 : k);
        end
        @(posedge clk); #1;
        total++; if (free_count !== 5'd8 || free_err !== 1'b0) begin
          bad++; $display("FAIL b2b_count[%0d][%0d] got count=%0d err=%b exp count=8 err=0", r, k, free_count, free_err);
        end
        total++; if ($countones(busy_vec) + int'(free_count) != 16) begin
          bad++; $display("FAIL b2b_invariant[%0d][%0d] got ones=%0d count=%0d exp sum=16", r, k, $countones(busy_vec), free_count);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    total++; if (busy_vec !== 16'h00FF) begin bad++; $display("FAIL b2b_busy got=%h exp=00ff", busy_vec); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(10);
    flush = 1'b1; alloc_req = 1'b1; free_en = 1'b1; free_tag = 4'd2;
    @(posedge clk); #1;
    @(negedge clk);
    idle_inputs();
    total++; if (free_count !== 5'd16 || busy_vec !== 16'h0000 || alloc_tag !== 4'd0) begin
      bad++; $display("FAIL flush_state got count=%0d busy=%h tag=%0d exp count=16 busy=0000 tag=0", free_count, busy_vec, alloc_tag);
    end
  endtask

  task automatic test_reset_priority();
    alloc_n(3);
    reset = 1'b1; flush = 1'b1; alloc_req = 1'b1; free_en = 1'b1; free_tag = 4'd9;
    @(posedge clk); #1;
    @(negedge clk);
    idle_inputs();
    total++; if (free_count !== 5'd16 || busy_vec !== 16'h0000 || alloc_tag !== 4'd0 || free_err !== 1'b0) begin
      bad++; $display("FAIL reset_prio got count=%0d busy=%h tag=%0d err=%b exp count=16 busy=0000 tag=0 err=0",
                      free_count, busy_vec, alloc_tag, free_err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    test_reset();
    test_fill();
    test_free_order();
    test_free_err();
    test_back_to_back();
    test_flush();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
